// File: rtl/push_pacer.sv
// push_pacer: debounces a raw push button and turns each accepted press into
// a request (transpush) that is held stable across exactly one rising edge of
// a locally generated slow clock (clk_1HZ) feeding a downstream toggle stage.
//
// Request protocol: transpush rises on the clk edge that accepts a press. It
// stays high through the next clk_1HZ rising edge that is generated after the
// acceptance. It drops on the same clk edge that drives clk_1HZ low again.
// The downstream stage therefore samples it high on exactly one clk_1HZ rise.
// While a request is outstanding, further presses are dropped and flagged on
// the sticky overrun output.
module push_pacer #(
  parameter int DIV_HALF   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       clk_1HZ,
  output logic       transpush,
  output logic       overrun,
  output logic [7:0] press_cnt,
  output logic [1:0] dbg_state
);

  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             deb_done;
  logic             press_evt;
  logic             div_tick;
  logic             rise_evt;
  logic             fall_evt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // The debounced level flips on the cycle that completes a full run of
  // disagreeing samples. A press is that flip when it goes 0->1, so the FSM
  // sees the event on the same edge the level changes.
  assign deb_done  = (sync2 != deb_level) && (deb_cnt == DEB_LAST);
  assign press_evt = deb_done && sync2;

  // Debounce: count consecutive disagreeing cycles; any agreeing cycle restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (sync2 == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_done) begin
      deb_level <= sync2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign div_tick = (div_cnt == DIV_LAST);
  assign rise_evt = div_tick && !clk_1HZ;
  assign fall_evt = div_tick && clk_1HZ;

  // Free-running divider: toggle clk_1HZ and wrap every DIV_HALF cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      clk_1HZ <= 1'b0;
    end else if (div_tick) begin
      div_cnt <= '0;
      clk_1HZ <= ~clk_1HZ;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Request FSM. ARMED only reacts to rise events seen after the arming edge,
  // because the IDLE branch ignores rise_evt entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      transpush <= 1'b0;
      overrun   <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (press_evt) begin
            state     <= ARMED;
            transpush <= 1'b1;
          end
        end
        ARMED: begin
          if (press_evt) begin
            overrun <= 1'b1;
          end
          if (rise_evt) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (press_evt) begin
            overrun <= 1'b1;
          end
          if (fall_evt) begin
            state     <= IDLE;
            transpush <= 1'b0;
            press_cnt <= press_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          transpush <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_push_pacer.sv
// tb_push_pacer: randomized and directed stimulus for push_pacer, checked
// against a cycle-level reference model derived from the behavioural rules.
module tb_push_pacer;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       clk_1HZ;
  logic       transpush;
  logic       overrun;
  logic [7:0] press_cnt;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  push_pacer #(
    .DIV_HALF   (DIV),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .clk_1HZ   (clk_1HZ),
    .transpush (transpush),
    .overrun   (overrun),
    .press_cnt (press_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: m_n counts clk edges since reset release, the slow
  // clock and its rise/fall events follow from m_n by plain arithmetic.
  int         m_n;
  int         m_run;
  logic       m_hist[$];
  logic       m_syn;
  logic       m_deb;
  logic       m_press;
  logic       m_rise;
  logic       m_fall;
  logic       m_req;
  logic       m_saw;
  logic       m_clk;
  logic       m_tp;
  logic       m_ovr;
  logic [7:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_run = 0; m_hist.delete(); m_deb = 0;
      m_req = 0; m_saw = 0; m_clk = 0; m_tp = 0; m_ovr = 0; m_cnt = 8'd0;
    end else begin
      m_n = m_n + 1;
      m_hist.push_back(btn);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      m_syn = (m_hist.size() == 3) ? m_hist[0] : 1'b0;
      m_press = 1'b0;
      if (m_syn != m_deb) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_deb = m_syn;
          m_run = 0;
          m_press = m_syn;
        end
      end else begin
        m_run = 0;
      end
      m_rise = (m_n % (2 * DIV)) == DIV;
      m_fall = (m_n % (2 * DIV)) == 0;
      m_clk  = ((m_n / DIV) % 2) == 1;
      if (m_req) begin
        if (m_press) m_ovr = 1'b1;
        if (m_saw && m_fall) begin
          m_req = 1'b0;
          m_cnt = m_cnt + 8'd1;
        end else if (m_rise) begin
          m_saw = 1'b1;
        end
      end else if (m_press) begin
        m_req = 1'b1;
        m_saw = 1'b0;
      end
      m_tp = m_req;
    end
  end

  function automatic logic [10:0] exp_vec();
    return {m_clk, m_tp, m_ovr, m_cnt};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {clk_1HZ, transpush, overrun, press_cnt};
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b1;
    #1;
    tests++;
    if (dut_vec() !== 11'd0) begin
      fails++;
      $display("FAIL reset_async got=%b exp=%b", dut_vec(), 11'd0);
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== 11'd0) begin
        fails++;
        $display("FAIL reset_held got=%b exp=%b", dut_vec(), 11'd0);
      end
    end
    btn = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_divider();
    int   first;
    int   toggles;
    logic prev;
    do_reset();
    first = -1; toggles = 0; prev = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL divider_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (clk_1HZ !== prev) toggles++;
      if (first < 0 && clk_1HZ === 1'b1) first = i;
      prev = clk_1HZ;
    end
    tests++;
    if (first != DIV) begin
      fails++;
      $display("FAIL divider_first_rise got=%0d exp=%0d", first, DIV);
    end
    tests++;
    if (toggles != 24 / DIV) begin
      fails++;
      $display("FAIL divider_toggles got=%0d exp=%0d", toggles, 24 / DIV);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      btn = (i < 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (transpush !== 1'b0 || press_cnt !== 8'd0) begin
      fails++;
      $display("FAIL bounce_reject got=%b/%0d exp=0/0", transpush, press_cnt);
    end
  endtask

  task automatic test_press();
    logic prev_clk;
    logic prev_tp;
    logic held_rise;
    logic clr_fall;
    do_reset();
    prev_clk = 1'b0; prev_tp = 1'b0; held_rise = 1'b0; clr_fall = 1'b0;
    for (int i = 0; i < 60; i++) begin
      btn = (i < 20) ? 1'b1 : 1'b0;
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL press_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (!prev_clk && clk_1HZ === 1'b1 && prev_tp && transpush === 1'b1) held_rise = 1'b1;
      if (prev_clk && clk_1HZ === 1'b0 && prev_tp && transpush === 1'b0) clr_fall = 1'b1;
      prev_clk = clk_1HZ;
      prev_tp  = transpush;
    end
    tests++;
    if (held_rise !== 1'b1 || clr_fall !== 1'b1) begin
      fails++;
      $display("FAIL press_window got=rise%b/fall%b exp=rise1/fall1", held_rise, clr_fall);
    end
    tests++;
    if (press_cnt !== 8'd1 || overrun !== 1'b0 || transpush !== 1'b0) begin
      fails++;
      $display("FAIL press_result got=cnt%0d/ovr%b/tp%b exp=cnt1/ovr0/tp0", press_cnt, overrun, transpush);
    end
  endtask

  task automatic test_overrun();
    int g;
    do_reset();
    g = 0;
    while ((m_n % (2 * DIV)) != 0 && g < 2 * DIV) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 42; i++) begin
      btn = (i < 3 || (i >= 6 && i < 12)) ? 1'b1 : 1'b0;
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL overrun_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (overrun !== 1'b1 || press_cnt !== 8'd1 || transpush !== 1'b0) begin
      fails++;
      $display("FAIL overrun_result got=ovr%b/cnt%0d/tp%b exp=ovr1/cnt1/tp0", overrun, press_cnt, transpush);
    end
  endtask

  task automatic test_coincide();
    int g;
    int high;
    do_reset();
    g = 0;
    while ((m_n % (2 * DIV)) != (2 * DIV - 1) && g < 2 * DIV) begin
      @(negedge clk);
      g++;
    end
    high = 0;
    for (int i = 0; i < 34; i++) begin
      btn = (i < 24) ? 1'b1 : 1'b0;
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL coincide_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (transpush === 1'b1) high++;
    end
    tests++;
    if (high != 3 * DIV || press_cnt !== 8'd1) begin
      fails++;
      $display("FAIL coincide_width got=%0d/cnt%0d exp=%0d/cnt1", high, press_cnt, 3 * DIV);
    end
  endtask

  task automatic test_reset_hold();
    int g;
    do_reset();
    btn = 1'b1;
    g = 0;
    while (!(m_req && m_saw) && g < 40) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL hold_model cyc=%0d got=%b exp=%b", g, dut_vec(), exp_vec());
      end
      g++;
    end
    tests++;
    if (!(m_req && m_saw) || transpush !== 1'b1) begin
      fails++;
      $display("FAIL hold_reached got=tp%b exp=tp1", transpush);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (dut_vec() !== 11'd0) begin
      fails++;
      $display("FAIL hold_async_reset got=%b exp=%b", dut_vec(), 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL hold_after_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (press_cnt !== 8'd0) begin
      fails++;
      $display("FAIL hold_no_count got=%0d exp=0", press_cnt);
    end
  endtask

  task automatic test_wrap();
    int g;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      btn = 1'b1;
      g = 0;
      while (!m_tp && g < 20) begin
        @(negedge clk);
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL wrap_model_arm p=%0d got=%b exp=%b", p, dut_vec(), exp_vec());
        end
        g++;
      end
      btn = 1'b0;
      g = 0;
      while (m_tp && g < 30) begin
        @(negedge clk);
        tests++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL wrap_model_done p=%0d got=%b exp=%b", p, dut_vec(), exp_vec());
        end
        g++;
      end
      if (m_tp) begin
        fails++;
        $display("FAIL wrap_timeout p=%0d got=pending exp=done", p);
      end
    end
    tests++;
    if (press_cnt !== 8'd0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL wrap_result got=cnt%0d/ovr%b exp=cnt0/ovr0", press_cnt, overrun);
    end
  endtask

  task automatic test_random();
    int left;
    do_reset();
    left = 0;
    for (int i = 0; i < 800; i++) begin
      if (left == 0) begin
        btn  = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 12);
      end
      left--;
      @(negedge clk);
      tests++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    btn = 1'b0;
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b0;
    btn = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_divider();
    test_bounce();
    test_press();
    test_overrun();
    test_coincide();
    test_reset_hold();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/push_pacer.md
PUSH_PACER -- requirements
Module: push_pacer

Interface
REQ-001 SHALL have parameter DIV_HALF, default 50000000, board-clock cycles per half period of clk_1HZ.
REQ-002 SHALL have parameter DEB_CYCLES, default 1000000, consecutive stable cycles required to accept a button level change.
REQ-003 SHALL have port clk  input  1  board clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn  input  1  raw, unsynchronised push button, active-high.
REQ-006 SHALL have port clk_1HZ  output  1  divided slow clock for the downstream toggle stage, registered.
REQ-007 SHALL have port transpush  output  1  press request to the toggle stage, registered, stable across exactly one clk_1HZ rising edge per accepted press.
REQ-008 SHALL have port overrun  output  1  sticky flag, press accepted while a request was still pending.
REQ-009 SHALL have port press_cnt  output  8  count of presses delivered to the toggle stage.

Function
REQ-010 SHALL pass btn through a two-flop synchroniser before any other use.
REQ-011 SHALL hold a debounced level that changes only after the synchronised input differs from it for DEB_CYCLES consecutive clk cycles; any agreeing cycle clears the run counter.
REQ-012 SHALL generate a one-cycle press event on the 0->1 transition of the debounced level; 1->0 produces no event.
REQ-013 SHALL run a divider counter 0..DIV_HALF-1, toggling clk_1HZ on the cycle the counter is DIV_HALF-1 and wrapping to 0 on that cycle.
REQ-014 SHALL define the internal rise event as the toggle cycle with clk_1HZ=0 and the fall event as the toggle cycle with clk_1HZ=1.
REQ-015 SHALL implement a three-state FSM: IDLE, ARMED, HOLD.
REQ-016 IDLE: transpush=0; press event -> ARMED, transpush set to 1 on the same clock edge.
REQ-017 ARMED: transpush=1; rise event -> HOLD; a rise event in the same cycle as the IDLE->ARMED transition SHALL NOT count.
REQ-018 HOLD: transpush=1; fall event -> IDLE, transpush cleared on the same clock edge clk_1HZ falls, press_cnt incremented by 1.
REQ-019 press_cnt SHALL wrap 255 -> 0 without flagging.
REQ-020 A press event in ARMED or HOLD SHALL be dropped, leave FSM and transpush unchanged, and set overrun to 1.
REQ-021 overrun SHALL remain 1 until reset.
REQ-022 The divider SHALL free-run independently of FSM state and button activity.

Reset
REQ-023 While rst=1, asynchronously: clk_1HZ=0, transpush=0, overrun=0, press_cnt=0, FSM=IDLE, divider and debounce counters=0, synchroniser flops and debounced level=0.
REQ-024 Reset asserted mid-request SHALL abort the request with no press_cnt increment.
REQ-025 After rst deasserts, the divider SHALL start from 0, so the first clk_1HZ rise occurs DIV_HALF cycles later.

Verification (DIV_HALF=4, DEB_CYCLES=3)
REQ-026 Release rst, btn=0 -> clk_1HZ toggles every 4 clk cycles (period 8), transpush=0, press_cnt=0.
REQ-027 btn pulse high 2 cycles -> rejected as bounce; transpush stays 0, press_cnt=0.
REQ-028 btn held high 20 cycles -> transpush=1 before next clk_1HZ rise, held through that rise, cleared at following fall; press_cnt=1, overrun=0.
REQ-029 Second clean press while transpush=1 -> no extra request, overrun=1, press_cnt=1 after request completes.
REQ-030 Press event coinciding with a rise event -> transpush held through the next rise (8 cycles later), cleared at the fall after it.
REQ-031 rst pulsed while FSM in HOLD -> all outputs 0 immediately; press_cnt stays 0.
